multi_channel_counter: RTL and testbench
========================================

Name: multi_channel_counter

Overview:
- Bank of CHANNELS independent WIDTH-bit counters.
- Each channel has:
  - per-channel up/down direction and a programmable terminal value (limit);
  - synchronous load;
  - wrap or saturate mode (build-time);
  - sticky overflow/underflow flags with clear;
  - a single-cycle terminal-count pulse.
- Sits beside timers/event logic as the general replacement for single fixed-width overflow counters.
- Also drives a combined interrupt-style summary flag.

Parameters:
- WIDTH, 4, bits per channel counter (>=2).
- CHANNELS, 2, number of independent counters (>=1).
- SATURATE, 0, 0 = wrap at terminal, 1 = hold at terminal.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high; clock clock.
- enable  input  CHANNELS  per-channel count enable.
- up  input  CHANNELS  direction per channel: 1 = increment, 0 = decrement.
- load  input  CHANNELS  per-channel synchronous load strobe.
- load_value  input  CHANNELS*WIDTH  load data; channel i uses bits [i*WIDTH +: WIDTH].
- limit  input  CHANNELS*WIDTH  per-channel terminal value (upper bound), same packing.
- flag_clear  input  CHANNELS  clears that channel's sticky flags.
- count  output  CHANNELS*WIDTH  registered counter values, same packing.
- overflow  output  CHANNELS  sticky: an up-count hit the terminal.
- underflow  output  CHANNELS  sticky: a down-count hit zero.
- tc_pulse  output  CHANNELS  one-cycle pulse on any terminal event.
- any_flag  output  1  OR of all overflow and underflow bits (registered-equivalent, no extra latency beyond the flags).

Behaviour:
- All state updates on the rising edge of clock. All outputs are registered except any_flag, which is combinational OR of registered flags.
- Reset (synchronous, active-high):
  - count = 0, overflow = 0, underflow = 0, tc_pulse = 0 for all channels.
  - Overrides every other input, including mid-count and mid-load.
- Per-channel priority: reset > load > enable. Channels are fully independent; no cross-channel interaction except any_flag.
- Load:
  - count <= load_value[i] next cycle, regardless of enable/up.
  - No flag set, tc_pulse = 0.
  - Load values above limit are accepted as-is.
- Up count (enable=1, up=1, load=0):
  - If count < limit: count+1.
  - If count >= limit (terminal event):
    - SATURATE=0: count <= 0.
    - SATURATE=1: count <= limit.
    - Either mode: overflow <= 1 and tc_pulse <= 1.
- Down count (enable=1, up=0, load=0):
  - If count > 0: count-1.
  - If count == 0 (terminal event):
    - SATURATE=0: count <= limit.
    - SATURATE=1: count stays 0.
    - Either mode: underflow <= 1 and tc_pulse <= 1.
- enable=0 and load=0: count holds, tc_pulse = 0.
- tc_pulse:
  - High exactly in the cycle after the edge that registered the terminal event.
  - In saturate mode with enable held, it re-pulses every cycle while pinned at the terminal.
- Flags:
  - Sticky until flag_clear[i] or reset.
  - Simultaneous set and clear in the same cycle: set wins (flag = 1).
  - flag_clear has no effect on count.
- limit is sampled live each cycle.
  - Lowering limit below the current count causes a terminal event on the next up-count.
  - limit = 0: up-count terminates every enabled cycle; down-wrap goes to 0.
- Arithmetic is modulo 2^WIDTH internally; no carry is exposed. With limit = 2^WIDTH-1, behaviour equals a plain free-running WIDTH-bit counter.

Test Plan:
- Setup: WIDTH=4, CHANNELS=2, SATURATE=0, limit ch0=15.
- Reset 2 cycles, then enable ch0 up for 17 cycles -> count0 goes 0..15, then 0 on cycle 16. overflow0=1, tc_pulse0 high one cycle, any_flag=1, ch1 count stays 0.
- ch1 limit=5, up=0, count=0, enable one cycle -> count1=5, underflow1=1, tc_pulse1 one cycle. Next enable -> count1=4, flags held.
- SATURATE=1 build, limit=9: count up from 7 for 5 cycles -> 8, 9, 9, 9, 9. overflow=1, tc_pulse high on each of the last three cycles.
- Load and enable together (load_value=12, enable=1, up=1) -> count=12, no flag. Then limit=10, one enable -> terminal: count=0 (wrap) and overflow=1.
- overflow=1, assert flag_clear with no event -> overflow=0 next cycle. Assert flag_clear in the same cycle as a terminal event -> overflow stays 1.
- Reset asserted mid-count at count=6 with load=1 simultaneously -> count=0, all flags 0, tc_pulse 0 the next cycle.

Source files
------------

// File: rtl/multi_channel_counter.sv
// Bank of independent up/down counters with programmable terminal value,
// sticky overflow/underflow flags and a one-cycle terminal-count pulse.
module multi_channel_counter #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int SATURATE = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          enable,
    input  logic [CHANNELS-1:0]          up,
    input  logic [CHANNELS-1:0]          load,
    input  logic [CHANNELS*WIDTH-1:0]    load_value,
    input  logic [CHANNELS*WIDTH-1:0]    limit,
    input  logic [CHANNELS-1:0]          flag_clear,
    output logic [CHANNELS*WIDTH-1:0]    count,
    output logic [CHANNELS-1:0]          overflow,
    output logic [CHANNELS-1:0]          underflow,
    output logic [CHANNELS-1:0]          tc_pulse,
    output logic                         any_flag
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] r_count;
            logic             r_overflow;
            logic             r_underflow;
            logic             r_tc_pulse;

            logic [WIDTH-1:0] w_limit;
            logic [WIDTH-1:0] w_load_value;
            logic [WIDTH-1:0] w_next;
            logic             w_up_term;
            logic             w_dn_term;

            assign w_limit      = limit[gi*WIDTH +: WIDTH];
            assign w_load_value = load_value[gi*WIDTH +: WIDTH];

            // Load masks counting, so a load never produces a terminal event.
            assign w_up_term = enable[gi] & up[gi] & ~load[gi] & (r_count >= w_limit);
            assign w_dn_term = enable[gi] & ~up[gi] & ~load[gi] & (r_count == '0);

            always_comb begin
                w_next = r_count;
                if (load[gi]) begin
                    w_next = w_load_value;
                end else if (enable[gi]) begin
                    if (up[gi]) begin
                        if (w_up_term)
                            w_next = (SATURATE != 0) ? w_limit : '0;
                        else
                            w_next = r_count + WIDTH'(1);
                    end else begin
                        if (w_dn_term)
                            w_next = (SATURATE != 0) ? '0 : w_limit;
                        else
                            w_next = r_count - WIDTH'(1);
                    end
                end
            end

            // Set has priority over a simultaneous clear.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_count     <= '0;
                    r_overflow  <= 1'b0;
                    r_underflow <= 1'b0;
                    r_tc_pulse  <= 1'b0;
                end else begin
                    r_count     <= w_next;
                    r_overflow  <= w_up_term | (r_overflow  & ~flag_clear[gi]);
                    r_underflow <= w_dn_term | (r_underflow & ~flag_clear[gi]);
                    r_tc_pulse  <= w_up_term | w_dn_term;
                end
            end

            assign count[gi*WIDTH +: WIDTH] = r_count;
            assign overflow[gi]             = r_overflow;
            assign underflow[gi]            = r_underflow;
            assign tc_pulse[gi]             = r_tc_pulse;
        end
    endgenerate

    assign any_flag = |(overflow | underflow);

endmodule

// File: tb/tb_multi_channel_counter.sv
// Bench for multi_channel_counter: wrap and saturate builds side by side,
// directed scenarios with literal expectations followed by random traffic.
module tb_multi_channel_counter;

    localparam int W  = 4;
    localparam int CH = 2;

    logic              clock;
    logic              rst;
    logic [CH-1:0]     en, upv, ld, clr;
    logic [CH*W-1:0]   lv, lim;

    logic [CH*W-1:0]   cnt_a, cnt_b;
    logic [CH-1:0]     ov_a, un_a, tc_a, ov_b, un_b, tc_b;
    logic              af_a, af_b;

    int n_cmp = 0;
    int n_bad = 0;

    multi_channel_counter #(.WIDTH(W), .CHANNELS(CH), .SATURATE(0)) u_wrap (
        .clock(clock), .reset(rst), .enable(en), .up(upv), .load(ld),
        .load_value(lv), .limit(lim), .flag_clear(clr),
        .count(cnt_a), .overflow(ov_a), .underflow(un_a), .tc_pulse(tc_a),
        .any_flag(af_a)
    );

    multi_channel_counter #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1)) u_sat (
        .clock(clock), .reset(rst), .enable(en), .up(upv), .load(ld),
        .load_value(lv), .limit(lim), .flag_clear(clr),
        .count(cnt_b), .overflow(ov_b), .underflow(un_b), .tc_pulse(tc_b),
        .any_flag(af_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: index 0 = wrap build, index 1 = saturate build.
    logic [W-1:0] m_cnt [2][CH];
    logic [CH-1:0] m_ov [2];
    logic [CH-1:0] m_un [2];
    logic [CH-1:0] m_tc [2];
    bit m_valid = 0;

    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                int l;
                int cur;
                bit t_up;
                bit t_dn;
                l    = int'(lim[c*W +: W]);
                cur  = int'(m_cnt[d][c]);
                t_up = 0;
                t_dn = 0;
                if (rst) begin
                    cur = 0;
                    m_ov[d][c] = 1'b0;
                    m_un[d][c] = 1'b0;
                    m_tc[d][c] = 1'b0;
                end else begin
                    if (ld[c]) begin
                        cur = int'(lv[c*W +: W]);
                    end else if (en[c] && upv[c]) begin
                        if (cur >= l) begin
                            t_up = 1;
                            cur  = (d == 1) ? l : 0;
                        end else begin
                            cur = cur + 1;
                        end
                    end else if (en[c]) begin
                        if (cur == 0) begin
                            t_dn = 1;
                            cur  = (d == 1) ? 0 : l;
                        end else begin
                            cur = cur - 1;
                        end
                    end
                    m_ov[d][c] = t_up | (m_ov[d][c] & ~clr[c]);
                    m_un[d][c] = t_dn | (m_un[d][c] & ~clr[c]);
                    m_tc[d][c] = t_up | t_dn;
                end
                m_cnt[d][c] = cur[W-1:0];
            end
        end
        if (rst) m_valid = 1;
    endfunction

    function automatic logic [CH*W-1:0] exp_cnt(input int d);
        logic [CH*W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*W +: W] = m_cnt[d][c];
        return v;
    endfunction

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (m_valid) begin
            check("wrap_count",     cnt_a, exp_cnt(0));
            check("wrap_overflow",  ov_a,  m_ov[0]);
            check("wrap_underflow", un_a,  m_un[0]);
            check("wrap_tc_pulse",  tc_a,  m_tc[0]);
            check("wrap_any_flag",  af_a,  |(m_ov[0] | m_un[0]));
            check("sat_count",      cnt_b, exp_cnt(1));
            check("sat_overflow",   ov_b,  m_ov[1]);
            check("sat_underflow",  un_b,  m_un[1]);
            check("sat_tc_pulse",   tc_b,  m_tc[1]);
            check("sat_any_flag",   af_b,  |(m_ov[1] | m_un[1]));
        end
    end

    int exp_sat_cnt [5] = '{8, 9, 9, 9, 9};
    int exp_sat_tc  [5] = '{0, 0, 1, 1, 1};
    int exp_wrap_cnt[5] = '{8, 9, 0, 1, 2};

    initial begin
        rst = 1'b1; en = '0; upv = '0; ld = '0; clr = '0; lv = '0; lim = 8'hFF;
        tick();
        tick();
        check("reset_count",    cnt_a, 0);
        check("reset_flags",    {ov_a, un_a, tc_a, af_a}, 0);
        check("reset_sat_count", cnt_b, 0);
        rst = 1'b0;

        // Full-range up-count on channel 0 with limit 15.
        en = 2'b01; upv = 2'b11;
        repeat (15) tick();
        check("up15_count0", cnt_a[3:0], 15);
        check("up15_model",  m_cnt[0][0], 15);
        check("up15_tc0",    tc_a[0], 0);
        tick();
        check("wrap16_count0", cnt_a[3:0], 0);
        check("wrap16_ovf0",   ov_a[0], 1);
        check("wrap16_tc0",    tc_a[0], 1);
        check("wrap16_any",    af_a, 1);
        check("wrap16_count1", cnt_a[7:4], 0);
        check("sat16_count0",  cnt_b[3:0], 15);
        tick();
        check("up17_count0", cnt_a[3:0], 1);
        check("up17_tc0",    tc_a[0], 0);
        check("up17_ovf0",   ov_a[0], 1);

        // Down-count from zero on channel 1 with limit 5.
        en = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        lim[7:4] = 4'd5; upv[1] = 1'b0; en = 2'b10;
        tick();
        check("dn_count1",     cnt_a[7:4], 5);
        check("dn_udf1",       un_a[1], 1);
        check("dn_tc1",        tc_a[1], 1);
        check("dn_sat_count1", cnt_b[7:4], 0);
        check("dn_sat_udf1",   un_b[1], 1);
        tick();
        check("dn2_count1", cnt_a[7:4], 4);
        check("dn2_tc1",    tc_a[1], 0);
        check("dn2_udf1",   un_a[1], 1);
        en = '0;

        // Approach limit 9 from 7 in both builds.
        lim[3:0] = 4'd9; lv[3:0] = 4'd7; ld = 2'b01;
        tick();
        ld = '0; en = 2'b01; upv[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("sat9_count0",  cnt_b[3:0], exp_sat_cnt[k]);
            check("sat9_tc0",     tc_b[0], exp_sat_tc[k]);
            check("wrap9_count0", cnt_a[3:0], exp_wrap_cnt[k]);
        end
        check("sat9_ovf0", ov_b[0], 1);

        // Load wins over enable; value above a later-lowered limit.
        en = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        lim[3:0] = 4'd15; lv[3:0] = 4'd12; ld = 2'b01; en = 2'b01; upv[0] = 1'b1;
        tick();
        check("load_count0", cnt_a[3:0], 12);
        check("load_ovf0",   ov_a[0], 0);
        check("load_tc0",    tc_a[0], 0);
        ld = '0; lim[3:0] = 4'd10;
        tick();
        check("lowlim_count0",     cnt_a[3:0], 0);
        check("lowlim_ovf0",       ov_a[0], 1);
        check("lowlim_sat_count0", cnt_b[3:0], 10);
        en = '0;

        // Clear alone, then clear colliding with a terminal event.
        clr = 2'b01;
        tick();
        check("clr_ovf0",     ov_a[0], 0);
        check("clr_sat_ovf0", ov_b[0], 0);
        check("clr_count0",   cnt_b[3:0], 10);
        clr = '0; lv[3:0] = 4'd10; ld = 2'b01;
        tick();
        ld = '0; en = 2'b01; clr = 2'b01;
        tick();
        check("setclr_ovf0",   ov_a[0], 1);
        check("setclr_tc0",    tc_a[0], 1);
        check("setclr_count0", cnt_a[3:0], 0);
        en = '0; clr = '0;

        // Reset overrides a simultaneous load and enable.
        lv[3:0] = 4'd6; ld = 2'b01;
        tick();
        check("pre_rst_count0", cnt_a[3:0], 6);
        rst = 1'b1; ld = 2'b11; en = 2'b11;
        tick();
        check("mid_rst_count", cnt_a, 0);
        check("mid_rst_flags", {ov_a, un_a, tc_a, af_a}, 0);
        check("mid_rst_sat",   {cnt_b, ov_b, un_b, tc_b}, 0);
        rst = 1'b0; ld = '0; en = '0;

        // Random traffic against the model.
        repeat (3000) begin
            rst = ($urandom_range(0, 127) == 0);
            en  = CH'($urandom);
            upv = CH'($urandom);
            for (int c = 0; c < CH; c++) begin
                ld[c]  = ($urandom_range(0, 7) == 0);
                clr[c] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    case ($urandom_range(0, 4))
                        0:       lim[c*W +: W] = '0;
                        1:       lim[c*W +: W] = '1;
                        default: lim[c*W +: W] = W'($urandom);
                    endcase
                end
            end
            lv = (CH*W)'($urandom);
            tick();
        end
        rst = 1'b0; en = '0; ld = '0; clr = '0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
